// File: rtl/pcpi_result_tx.sv
// pcpi_result_tx
//   Captures 32-bit results written back by the PCPI matrix-multiply
//   coprocessor into a small FIFO. Each word is then sent to the off-chip
//   host one nibble at a time, least significant nibble first, over a
//   4-phase req/ack handshake. This is the output-side twin of the
//   nibble-serial instruction input path.
//
// Handshake (valid/ready style, 4-phase):
//   res_valid acts as the request. It rises with a stable res_nibble.
//   The host raises host_ack once it has sampled the nibble.
//   res_valid then drops, and the host must drop host_ack.
//   Only then is the next nibble presented.
//   res_last marks the final nibble of a word.
//   A new word starts only while host_ack is low.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pcpi_ready/pcpi_wr  push pcpi_rd when both are high
//   pcpi_rd             coprocessor result word
//   host_ack            host acknowledge for the current nibble
//   res_valid           res_nibble is valid
//   res_nibble          current nibble
//   res_last            final nibble of the word
//   busy                FIFO non-empty or a word is in flight
//   overflow            sticky: a result was dropped because the FIFO was full
//   fifo_count          number of words queued
module pcpi_result_tx #(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pcpi_ready,
  input  logic                       pcpi_wr,
  input  logic [DATA_W-1:0]          pcpi_rd,
  input  logic                       host_ack,
  output logic                       res_valid,
  output logic [NIB_W-1:0]           res_nibble,
  output logic                       res_last,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int NIBS  = DATA_W / NIB_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESENT      = 2'd1,
    S_WAIT_ACK_LOW = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                res_valid_q, res_valid_d;
  logic [NIB_W-1:0]    res_nibble_q, res_nibble_d;
  logic                res_last_q, res_last_d;

  logic                pop;
  logic                push_req;
  logic                push_ok;
  logic [IDX_W-1:0]    idx_nxt;

  // Words leave the FIFO only from IDLE. A held-high ack blocks the start
  // of a word so the host never sees a nibble it has already acknowledged.
  assign pop      = (state_q == S_IDLE) && (count_q != '0) && !host_ack;
  assign push_req = pcpi_ready && pcpi_wr;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push_ok  = push_req && ((count_q != FULL_CNT) || pop);
  assign idx_nxt  = idx_q + IDX_W'(1);

  // State register (all flops)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      sr_q         <= '0;
      idx_q        <= '0;
      res_valid_q  <= 1'b0;
      res_nibble_q <= '0;
      res_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      sr_q         <= sr_d;
      idx_q        <= idx_d;
      res_valid_q  <= res_valid_d;
      res_nibble_q <= res_nibble_d;
      res_last_q   <= res_last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (pop) state_d = S_PRESENT;
      S_PRESENT:      if (host_ack) state_d = S_WAIT_ACK_LOW;
      S_WAIT_ACK_LOW: if (!host_ack) state_d = (idx_q == LAST_IDX) ? S_IDLE : S_PRESENT;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic: registered handshake outputs and shift register
  always_comb begin
    sr_d         = sr_q;
    idx_d        = idx_q;
    res_valid_d  = res_valid_q;
    res_nibble_d = res_nibble_q;
    res_last_d   = res_last_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          sr_d         = mem_q[rd_ptr_q];
          idx_d        = '0;
          res_valid_d  = 1'b1;
          res_nibble_d = mem_q[rd_ptr_q][NIB_W-1:0];
          res_last_d   = (LAST_IDX == '0);
        end
      end
      S_PRESENT: begin
        if (host_ack) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
        end
      end
      S_WAIT_ACK_LOW: begin
        if (!host_ack && (idx_q != LAST_IDX)) begin
          sr_d         = sr_q >> NIB_W;
          idx_d        = idx_nxt;
          res_valid_d  = 1'b1;
          res_nibble_d = sr_d[NIB_W-1:0];
          res_last_d   = (idx_nxt == LAST_IDX);
        end
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req && !push_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = pcpi_rd;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign res_valid  = res_valid_q;
  assign res_nibble = res_nibble_q;
  assign res_last   = res_last_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule
